n64rgb_vdemux: RTL and testbench

Video-bus demultiplexer sitting between the N64 digital video port and the DAC output stage. Splits the 4-phase multiplexed bus (sync, R, G, B per pixel) into parallel registered pixel words and applies the 15-bit colour mask and the de-blur blanking selected by the housekeeping block. It also derives the interlace flag `n64_480i` that the housekeeping block consumes.

---
 rtl/n64rgb_vdemux_if.sv | 26 ++
 rtl/n64rgb_vdemux.sv | 145 ++++++++++++++
 tb/tb_n64rgb_vdemux.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/n64rgb_vdemux_if.sv
// N64 video bus bundle: multiplexed input bus, mode controls and the
// demultiplexed pixel outputs of n64rgb_vdemux.
interface n64rgb_vdemux_if;
    logic       nDSYNC_i;
    logic [6:0] D_i;
    logic       nDeBlur_i;
    logic       n15bit_i;
    logic [3:0] nSYNC_o;
    logic [6:0] R_o;
    logic [6:0] G_o;
    logic [6:0] B_o;
    logic       pix_stb_o;
    logic       n64_480i;

    // Driver side: the console bus and housekeeping controls
    modport master (
        output nDSYNC_i, D_i, nDeBlur_i, n15bit_i,
        input  nSYNC_o, R_o, G_o, B_o, pix_stb_o, n64_480i
    );

    // Demultiplexer side
    modport slave (
        input  nDSYNC_i, D_i, nDeBlur_i, n15bit_i,
        output nSYNC_o, R_o, G_o, B_o, pix_stb_o, n64_480i
    );
endinterface

// File: rtl/n64rgb_vdemux.sv
// N64 video demultiplexer: splits the 4-phase sync/R/G/B bus into parallel
// registered pixel words, applies 15-bit masking and de-blur blanking, and
// detects interlaced sources from the HSYNC level at VSYNC falling edges.
module n64rgb_vdemux (
    input logic             VCLK,
    input logic             nRST,
    n64rgb_vdemux_if.slave  vbus
);

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_R    = 2'd1,
        PH_G    = 2'd2,
        PH_B    = 2'd3
    } phase_e;

    phase_e     ph_q, ph_d;
    logic [3:0] s_hold_q, s_hold_d;
    logic [6:0] r_hold_q, r_hold_d;
    logic [6:0] g_hold_q, g_hold_d;
    logic [3:0] sync_out_q, sync_out_d;
    logic [6:0] r_out_q, r_out_d;
    logic [6:0] g_out_q, g_out_d;
    logic [6:0] b_out_q, b_out_d;
    logic       stb_q, stb_d;
    logic       odd_q, odd_d;
    logic [3:0] prev_sync_q, prev_sync_d;
    logic       last_frame_id_q, last_frame_id_d;
    logic       n480i_q, n480i_d;

    // Blanking beats the 15-bit mask; the mask clears the two LSBs
    function automatic logic [6:0] colour(input logic [6:0] v,
                                          input logic       blank,
                                          input logic       n15bit);
        if (blank)
            return '0;
        else if (!n15bit)
            return {v[6:2], 2'b00};
        else
            return v;
    endfunction

    // State and pipeline registers
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            ph_q            <= PH_IDLE;
            s_hold_q        <= '0;
            r_hold_q        <= '0;
            g_hold_q        <= '0;
            sync_out_q      <= '1;
            r_out_q         <= '0;
            g_out_q         <= '0;
            b_out_q         <= '0;
            stb_q           <= 1'b0;
            odd_q           <= 1'b0;
            prev_sync_q     <= '1;
            last_frame_id_q <= 1'b1;
            n480i_q         <= 1'b0;
        end else begin
            ph_q            <= ph_d;
            s_hold_q        <= s_hold_d;
            r_hold_q        <= r_hold_d;
            g_hold_q        <= g_hold_d;
            sync_out_q      <= sync_out_d;
            r_out_q         <= r_out_d;
            g_out_q         <= g_out_d;
            b_out_q         <= b_out_d;
            stb_q           <= stb_d;
            odd_q           <= odd_d;
            prev_sync_q     <= prev_sync_d;
            last_frame_id_q <= last_frame_id_d;
            n480i_q         <= n480i_d;
        end
    end

    // Phase sequencing, capture, and pixel commit with mask/de-blur/interlace
    always_comb begin
        logic hsync_fall;
        logic vsync_fall;
        logic odd_cur;
        logic blank;
        logic frame_id;

        ph_d            = ph_q;
        s_hold_d        = s_hold_q;
        r_hold_d        = r_hold_q;
        g_hold_d        = g_hold_q;
        sync_out_d      = sync_out_q;
        r_out_d         = r_out_q;
        g_out_d         = g_out_q;
        b_out_d         = b_out_q;
        stb_d           = 1'b0;
        odd_d           = odd_q;
        prev_sync_d     = prev_sync_q;
        last_frame_id_d = last_frame_id_q;
        n480i_d         = n480i_q;

        hsync_fall = prev_sync_q[1] & ~s_hold_q[1];
        vsync_fall = prev_sync_q[3] & ~s_hold_q[3];
        odd_cur    = hsync_fall ? 1'b0 : odd_q;
        blank      = ~vbus.nDeBlur_i & ~n480i_q & odd_cur;
        frame_id   = s_hold_q[1];

        if (!vbus.nDSYNC_i) begin
            // Sync phase restarts the pixel from any phase
            s_hold_d = vbus.D_i[3:0];
            ph_d     = PH_R;
        end else begin
            unique case (ph_q)
                PH_IDLE: ;
                PH_R: begin
                    r_hold_d = vbus.D_i;
                    ph_d     = PH_G;
                end
                PH_G: begin
                    g_hold_d = vbus.D_i;
                    ph_d     = PH_B;
                end
                PH_B: begin
                    sync_out_d  = s_hold_q;
                    r_out_d     = colour(r_hold_q, blank, vbus.n15bit_i);
                    g_out_d     = colour(g_hold_q, blank, vbus.n15bit_i);
                    b_out_d     = colour(vbus.D_i, blank, vbus.n15bit_i);
                    stb_d       = 1'b1;
                    odd_d       = ~odd_cur;
                    prev_sync_d = s_hold_q;
                    if (vsync_fall) begin
                        n480i_d         = (frame_id != last_frame_id_q);
                        last_frame_id_d = frame_id;
                    end
                    ph_d = PH_IDLE;
                end
                default: ph_d = PH_IDLE;
            endcase
        end
    end

    assign vbus.nSYNC_o   = sync_out_q;
    assign vbus.R_o       = r_out_q;
    assign vbus.G_o       = g_out_q;
    assign vbus.B_o       = b_out_q;
    assign vbus.pix_stb_o = stb_q;
    assign vbus.n64_480i  = n480i_q;

endmodule

// File: tb/tb_n64rgb_vdemux.sv
// Directed bench for n64rgb_vdemux with a scoreboard of expected pixels.
module tb_n64rgb_vdemux;

    typedef struct {
        logic [3:0] s;
        logic [6:0] r;
        logic [6:0] g;
        logic [6:0] b;
    } pix_t;

    logic VCLK = 1'b0;
    logic nRST = 1'b0;
    int   tests = 0;
    int   fails = 0;
    pix_t sb[$];

    n64rgb_vdemux_if vbus ();

    n64rgb_vdemux dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .vbus (vbus.slave)
    );

    always #5 VCLK = ~VCLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every strobed pixel against the oldest expected entry
    always @(negedge VCLK) begin
        if (vbus.pix_stb_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 8'd1, 8'd0);
            end else begin
                pix_t e;
                e = sb.pop_front();
                check("nSYNC", {4'h0, vbus.nSYNC_o}, {4'h0, e.s});
                check("R", {1'b0, vbus.R_o}, {1'b0, e.r});
                check("G", {1'b0, vbus.G_o}, {1'b0, e.g});
                check("B", {1'b0, vbus.B_o}, {1'b0, e.b});
            end
        end
    end

    task automatic cyc(input logic nd, input logic [6:0] d);
        vbus.nDSYNC_i = nd;
        vbus.D_i      = d;
        @(posedge VCLK);
        #1;
    endtask

    // Full pixel: sync, R, G, B; expected result queued before the commit edge
    task automatic pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                         input logic [6:0] b, input logic [6:0] er, input logic [6:0] eg,
                         input logic [6:0] eb);
        pix_t e;
        cyc(1'b0, {3'b000, s});
        cyc(1'b1, r);
        cyc(1'b1, g);
        e.s = s; e.r = er; e.g = eg; e.b = eb;
        sb.push_back(e);
        cyc(1'b1, b);
        check("stb_at_commit", {7'd0, vbus.pix_stb_o}, 8'd1);
        @(negedge VCLK);
        #1;
        check("latency_sb_empty", 8'(sb.size()), 8'd0);
    endtask

    task automatic pix7f(input logic [3:0] s, input logic [6:0] ev);
        pixel(s, 7'h7F, 7'h7F, 7'h7F, ev, ev, ev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vbus.nDSYNC_i  = 1'b1;
        vbus.D_i       = '0;
        vbus.nDeBlur_i = 1'b1;
        vbus.n15bit_i  = 1'b1;
        #22;
        check("rst_nSYNC", {4'h0, vbus.nSYNC_o}, 8'h0F);
        check("rst_R", {1'b0, vbus.R_o}, 8'h00);
        check("rst_stb", {7'd0, vbus.pix_stb_o}, 8'd0);
        check("rst_480i", {7'd0, vbus.n64_480i}, 8'd0);
        @(posedge VCLK);
        #1;
        nRST = 1'b1;
        cyc(1'b1, 7'h00);

        // Basic pixel, masks off
        pixel(4'hF, 7'h55, 7'h2A, 7'h7F, 7'h55, 7'h2A, 7'h7F);
        cyc(1'b1, 7'h00);
        check("stb_one_cycle", {7'd0, vbus.pix_stb_o}, 8'd0);
        check("hold_R", {1'b0, vbus.R_o}, 8'h55);

        // 15-bit mask
        vbus.n15bit_i = 1'b0;
        pixel(4'hF, 7'h55, 7'h2A, 7'h7F, 7'h54, 7'h28, 7'h7C);
        vbus.n15bit_i = 1'b1;

        // De-blur line, HSYNC falls on pixel 0
        vbus.nDeBlur_i = 1'b0;
        pix7f(4'b1101, 7'h7F);
        pix7f(4'b1101, 7'h00);
        pix7f(4'b1101, 7'h7F);
        pix7f(4'b1101, 7'h00);
        pix7f(4'b1101, 7'h7F);
        pix7f(4'b1101, 7'h00);
        vbus.nDeBlur_i = 1'b1;

        // Interlace detection: falls with nHSYNC=1 then 0
        pix7f(4'hF, 7'h7F);
        pix7f(4'b0111, 7'h7F);
        check("480i_first_fall", {7'd0, vbus.n64_480i}, 8'd0);
        pix7f(4'hF, 7'h7F);
        pix7f(4'b0101, 7'h7F);
        check("480i_set", {7'd0, vbus.n64_480i}, 8'd1);

        // De-blur suppressed while interlaced
        vbus.nDeBlur_i = 1'b0;
        pix7f(4'hF, 7'h7F);
        pix7f(4'b1101, 7'h7F);
        pix7f(4'b1101, 7'h7F);
        pix7f(4'b1101, 7'h7F);
        vbus.nDeBlur_i = 1'b1;
        check("480i_held", {7'd0, vbus.n64_480i}, 8'd1);

        // Two further falls with nHSYNC=0
        pix7f(4'hF, 7'h7F);
        pix7f(4'b0101, 7'h7F);
        check("480i_clear1", {7'd0, vbus.n64_480i}, 8'd0);
        pix7f(4'hF, 7'h7F);
        pix7f(4'b0101, 7'h7F);
        check("480i_clear2", {7'd0, vbus.n64_480i}, 8'd0);

        // Sync re-asserted in the G slot aborts the pixel
        cyc(1'b0, 7'h0F);
        cyc(1'b1, 7'h11);
        pixel(4'hF, 7'h33, 7'h44, 7'h55, 7'h33, 7'h44, 7'h55);

        // Consecutive sync cycles: last one wins
        cyc(1'b0, 7'h00);
        pixel(4'hE, 7'h01, 7'h02, 7'h03, 7'h01, 7'h02, 7'h03);

        // Reset asserted during the B phase
        cyc(1'b0, 7'h0F);
        cyc(1'b1, 7'h12);
        cyc(1'b1, 7'h34);
        vbus.D_i = 7'h56;
        #2;
        nRST = 1'b0;
        #1;
        check("arst_nSYNC", {4'h0, vbus.nSYNC_o}, 8'h0F);
        check("arst_R", {1'b0, vbus.R_o}, 8'h00);
        check("arst_B", {1'b0, vbus.B_o}, 8'h00);
        check("arst_stb", {7'd0, vbus.pix_stb_o}, 8'd0);
        @(posedge VCLK);
        #1;
        nRST = 1'b1;
        // Data without a sync phase must not commit
        cyc(1'b1, 7'h12);
        cyc(1'b1, 7'h34);
        cyc(1'b1, 7'h56);
        cyc(1'b1, 7'h78);
        check("no_commit_after_rst", {1'b0, vbus.R_o}, 8'h00);
        pixel(4'hF, 7'h21, 7'h43, 7'h65, 7'h21, 7'h43, 7'h65);

        cyc(1'b1, 7'h00);
        cyc(1'b1, 7'h00);
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
